// File: rtl/biriscv_fq_pkg.sv
// Fetch queue package: entry layout shared by the queue and its slot mask.
// Entry bit layout is {pc[31:2], instr, pred, fault_fetch, fault_page}.
// PC bits [1:0] are implied zero and never stored.
package biriscv_fq_pkg;

    localparam int PC_W    = 30;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               pred;
        logic               fault_fetch;
        logic               fault_page;
    } fq_entry_t;

    // Rebuild the full byte address from a stored entry.
    function automatic logic [31:0] entry_pc(input fq_entry_t e);
        return {e.pc, 2'b00};
    endfunction

endpackage

// File: rtl/biriscv_fq_slot_mask.sv
// Fetch queue slot mask: decides which slots of an incoming packet are kept.
// Kept slots form one contiguous run starting at the start slot and ending at
// the first predicted-taken slot (inclusive). A faulting packet keeps only the
// start slot.
module biriscv_fq_slot_mask #(
    parameter int FETCH_W = 2,
    parameter int CNT_W   = 2
) (
    input  logic [7:0]         i_start,
    input  logic [FETCH_W-1:0] i_pred,
    input  logic               i_fault,
    output logic [FETCH_W-1:0] o_mask,
    output logic [CNT_W-1:0]   o_count
);

    logic w_blocked;

    // Walk the slots in order, closing the run after the first taken branch
    always_comb begin
        o_mask    = '0;
        o_count   = '0;
        w_blocked = 1'b0;
        for (int k = 0; k < FETCH_W; k++) begin
            if (i_fault) begin
                o_mask[k] = (8'(k) == i_start);
            end else if ((8'(k) >= i_start) && !w_blocked) begin
                o_mask[k] = 1'b1;
                if (i_pred[k]) begin
                    w_blocked = 1'b1;
                end
            end
            if (o_mask[k]) begin
                o_count = o_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/biriscv_fetch_queue.sv
// Fetch queue top: unpacks fetch packets into a circular per-instruction
// buffer and presents the oldest entries on ISSUE_W in-order lanes.
// Optional feature macro: BIRISCV_FQ_BYPASS_EN -- when defined, an empty
// queue forwards the incoming packet straight to the output lanes.
module biriscv_fetch_queue
    import biriscv_fq_pkg::*;
#(
    parameter int FETCH_W   = 2,
    parameter int FETCH_W_W = 1,
    parameter int ISSUE_W   = 2,
    parameter int DEPTH     = 8,
    parameter int DEPTH_W   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   fetch_valid_i,
    input  logic [32*FETCH_W-1:0]  fetch_instr_i,
    input  logic [31:0]            fetch_pc_i,
    input  logic [FETCH_W-1:0]     fetch_pred_branch_i,
    input  logic                   fetch_fault_fetch_i,
    input  logic                   fetch_fault_page_i,
    output logic                   fetch_accept_o,
    input  logic                   branch_request_i,
    output logic [ISSUE_W-1:0]     out_valid_o,
    output logic [32*ISSUE_W-1:0]  out_instr_o,
    output logic [32*ISSUE_W-1:0]  out_pc_o,
    output logic [ISSUE_W-1:0]     out_pred_branch_o,
    output logic [ISSUE_W-1:0]     out_fault_fetch_o,
    output logic [ISSUE_W-1:0]     out_fault_page_o,
    input  logic [ISSUE_W-1:0]     out_accept_i,
    output logic [DEPTH_W:0]       level_o
);

    localparam int CNT_W = $clog2(FETCH_W + 1);
    localparam int POP_W = $clog2(ISSUE_W + 1);
    localparam int LVL_W = DEPTH_W + 1;

    fq_entry_t          r_mem [DEPTH];
    logic [DEPTH_W-1:0] r_rd_ptr;
    logic [DEPTH_W-1:0] r_wr_ptr;
    logic [LVL_W-1:0]   r_count;

    logic [7:0]         w_start;
    logic               w_fault;
    logic [FETCH_W-1:0] w_mask;
    logic [CNT_W-1:0]   w_push_cnt;
    logic               w_push;
    fq_entry_t          w_pkt [FETCH_W];
    fq_entry_t          w_lane [ISSUE_W];
    logic [ISSUE_W-1:0] w_lane_vld;
    logic [POP_W-1:0]   w_pop_cnt;
    logic               w_run;
    logic               w_unused_pc;

    assign w_start     = fetch_pc_i[9:2] & 8'(FETCH_W - 1);
    assign w_fault     = fetch_fault_fetch_i | fetch_fault_page_i;
    assign w_unused_pc = ^fetch_pc_i[1:0];

    // Room for a whole packet is judged on the current level only
    assign fetch_accept_o = rst_ni && ((LVL_W'(DEPTH) - r_count) >= LVL_W'(FETCH_W));
    assign w_push         = fetch_valid_i && fetch_accept_o && !branch_request_i;
    assign level_o        = r_count;

    biriscv_fq_slot_mask #(
        .FETCH_W (FETCH_W),
        .CNT_W   (CNT_W)
    ) u_slot_mask (
        .i_start (w_start),
        .i_pred  (fetch_pred_branch_i),
        .i_fault (w_fault),
        .o_mask  (w_mask),
        .o_count (w_push_cnt)
    );

    // Compact kept slots: pushed entry i is slot start+i
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            w_pkt[i] = '0;
            for (int k = 0; k < FETCH_W; k++) begin
                if (w_mask[k] && (8'(k) == (w_start + 8'(i)))) begin
                    w_pkt[i].pc          = (fetch_pc_i[31:2] & ~30'((1 << FETCH_W_W) - 1)) | 30'(k);
                    w_pkt[i].instr       = w_fault ? '0 : fetch_instr_i[32*k +: 32];
                    w_pkt[i].pred        = !w_fault && fetch_pred_branch_i[k];
                    w_pkt[i].fault_fetch = fetch_fault_fetch_i;
                    w_pkt[i].fault_page  = fetch_fault_page_i;
                end
            end
        end
    end

    // Lane i shows entry rd_ptr+i (or the live packet when bypassing an empty queue)
    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            w_lane[i]     = r_mem[r_rd_ptr + DEPTH_W'(i)];
            w_lane_vld[i] = (r_count > LVL_W'(i)) && !branch_request_i;
`ifdef BIRISCV_FQ_BYPASS_EN
            if ((r_count == '0) && w_push) begin
                w_lane[i]     = w_pkt[i % FETCH_W];
                w_lane_vld[i] = (i < FETCH_W) && (i < int'(w_push_cnt));
            end
`endif
        end
    end

    // Pop count is the leading run of accepted valid lanes
    always_comb begin
        w_pop_cnt = '0;
        w_run     = 1'b1;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_run = w_run & out_accept_i[i] & w_lane_vld[i];
            if (w_run) begin
                w_pop_cnt = w_pop_cnt + POP_W'(1);
            end
        end
    end

    // Drive lane outputs; invalid lanes read as zero
    always_comb begin
        out_valid_o       = '0;
        out_instr_o       = '0;
        out_pc_o          = '0;
        out_pred_branch_o = '0;
        out_fault_fetch_o = '0;
        out_fault_page_o  = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid_o[i] = w_lane_vld[i];
            if (w_lane_vld[i]) begin
                out_instr_o[32*i +: 32] = w_lane[i].instr;
                out_pc_o[32*i +: 32]    = entry_pc(w_lane[i]);
                out_pred_branch_o[i]    = w_lane[i].pred;
                out_fault_fetch_o[i]    = w_lane[i].fault_fetch;
                out_fault_page_o[i]     = w_lane[i].fault_page;
            end
        end
    end

    // Pointers and level; a flush discards same-cycle pushes and pops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (branch_request_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_W'(w_push_cnt);
            end
            r_rd_ptr <= r_rd_ptr + DEPTH_W'(w_pop_cnt);
            r_count  <= r_count + (w_push ? LVL_W'(w_push_cnt) : '0) - LVL_W'(w_pop_cnt);
        end
    end

    // Entry storage has no reset; only kept slots are written
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (i < int'(w_push_cnt)) begin
                    r_mem[r_wr_ptr + DEPTH_W'(i)] <= w_pkt[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Bench for biriscv_fetch_queue: queue-based reference model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_biriscv_fetch_queue;

    localparam int FW = 2;
    localparam int IW = 2;
    localparam int D  = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            fetch_valid_i;
    logic [32*FW-1:0] fetch_instr_i;
    logic [31:0]     fetch_pc_i;
    logic [FW-1:0]   fetch_pred_branch_i;
    logic            fetch_fault_fetch_i;
    logic            fetch_fault_page_i;
    logic            fetch_accept_o;
    logic            branch_request_i;
    logic [IW-1:0]   out_valid_o;
    logic [32*IW-1:0] out_instr_o;
    logic [32*IW-1:0] out_pc_o;
    logic [IW-1:0]   out_pred_branch_o;
    logic [IW-1:0]   out_fault_fetch_o;
    logic [IW-1:0]   out_fault_page_o;
    logic [IW-1:0]   out_accept_i;
    logic [3:0]      level_o;

    biriscv_fetch_queue #(
        .FETCH_W(FW), .FETCH_W_W(1), .ISSUE_W(IW), .DEPTH(D), .DEPTH_W(3)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .fetch_valid_i       (fetch_valid_i),
        .fetch_instr_i       (fetch_instr_i),
        .fetch_pc_i          (fetch_pc_i),
        .fetch_pred_branch_i (fetch_pred_branch_i),
        .fetch_fault_fetch_i (fetch_fault_fetch_i),
        .fetch_fault_page_i  (fetch_fault_page_i),
        .fetch_accept_o      (fetch_accept_o),
        .branch_request_i    (branch_request_i),
        .out_valid_o         (out_valid_o),
        .out_instr_o         (out_instr_o),
        .out_pc_o            (out_pc_o),
        .out_pred_branch_o   (out_pred_branch_o),
        .out_fault_fetch_o   (out_fault_fetch_o),
        .out_fault_page_o    (out_fault_page_o),
        .out_accept_i        (out_accept_i),
        .level_o             (level_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
        logic        ff;
        logic        fp;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of instructions
    ent_t        pushed[$];
    ent_t        vis[$];
    ent_t        e;
    int          lvl, start, npop;
    bit          acc, do_push, run;
    logic [IW-1:0] exp_valid;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            q.delete();
            chk("rst_level", 64'(level_o), 0);
            chk("rst_accept", 64'(fetch_accept_o), 0);
            chk("rst_valid", 64'(out_valid_o), 0);
            chk("rst_instr", 64'(out_instr_o), 0);
            chk("rst_pc", 64'(out_pc_o), 0);
            chk("rst_flags", 64'({out_pred_branch_o, out_fault_fetch_o, out_fault_page_o}), 0);
        end else begin
            lvl = q.size();
            acc = (D - lvl) >= FW;
            do_push = fetch_valid_i && acc && !branch_request_i;
            pushed.delete();
            if (do_push) begin
                start = int'((fetch_pc_i >> 2) % FW);
                for (int k = start; k < FW; k++) begin
                    e.pc = (fetch_pc_i / (4 * FW)) * (4 * FW) + 32'(4 * k);
                    e.ff = fetch_fault_fetch_i;
                    e.fp = fetch_fault_page_i;
                    if (fetch_fault_fetch_i || fetch_fault_page_i) begin
                        e.instr = 0;
                        e.pred  = 0;
                        pushed.push_back(e);
                        break;
                    end
                    e.instr = fetch_instr_i[32*k +: 32];
                    e.pred  = fetch_pred_branch_i[k];
                    pushed.push_back(e);
                    if (e.pred) break;
                end
            end
            vis = q;
`ifdef BIRISCV_FQ_BYPASS_EN
            if (lvl == 0) vis = pushed;
`endif
            chk("level", 64'(level_o), 64'(lvl));
            chk("fetch_accept", 64'(fetch_accept_o), 64'(acc));
            for (int i = 0; i < IW; i++) exp_valid[i] = (i < vis.size()) && !branch_request_i;
            chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
            npop = 0;
            run  = 1;
            for (int i = 0; i < IW; i++) begin
                if (exp_valid[i]) begin
                    chk("lane_pc", 64'(out_pc_o[32*i +: 32]), 64'(vis[i].pc));
                    chk("lane_instr", 64'(out_instr_o[32*i +: 32]), 64'(vis[i].instr));
                    chk("lane_flags", 64'({out_pred_branch_o[i], out_fault_fetch_o[i], out_fault_page_o[i]}),
                        64'({vis[i].pred, vis[i].ff, vis[i].fp}));
                end
                run = run && out_accept_i[i] && exp_valid[i];
                if (run) npop++;
            end
            if (branch_request_i) begin
                q.delete();
            end else begin
                foreach (pushed[j]) q.push_back(pushed[j]);
                repeat (npop) void'(q.pop_front());
            end
        end
    end

    task automatic idle();
        fetch_valid_i       = 1'b0;
        branch_request_i    = 1'b0;
        out_accept_i        = '0;
        fetch_fault_fetch_i = 1'b0;
        fetch_fault_page_i  = 1'b0;
        fetch_pred_branch_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        idle();
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [1:0] pred, input bit ff,
                        input bit fp, input logic [1:0] acc_lanes);
        fetch_valid_i       = 1'b1;
        fetch_pc_i          = pc;
        fetch_pred_branch_i = pred;
        fetch_fault_fetch_i = ff;
        fetch_fault_page_i  = fp;
        fetch_instr_i       = {$urandom, $urandom};
        out_accept_i        = acc_lanes;
    endtask

    initial begin
        idle();
        fetch_pc_i    = '0;
        fetch_instr_i = '0;
        rst_ni        = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("lit_rst_accept", 64'(fetch_accept_o), 0);
        rst_ni = 1'b1;
        #1;
        chk("lit_accept_after_rst", 64'(fetch_accept_o), 1);

        // Unaligned start: only slot 1 kept
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h1004;
        fetch_instr_i = {32'hAAAA_0001, 32'hBBBB_0000};
        tick();
        chk("lit_unaligned_level", 64'(level_o), 1);
        chk("lit_unaligned_valid", 64'(out_valid_o), 64'h1);
        chk("lit_unaligned_pc", 64'(out_pc_o[31:0]), 64'h1004);
        chk("lit_unaligned_instr", 64'(out_instr_o[31:0]), 64'hAAAA_0001);
        out_accept_i = 2'b11;
        tick();
        chk("lit_drain1", 64'(level_o), 0);

        // Taken branch in slot 0 drops slot 1
        send(32'h2000, 2'b01, 0, 0, 2'b00);
        tick();
        chk("lit_pred_level", 64'(level_o), 1);
        chk("lit_pred_bit", 64'(out_pred_branch_o[0]), 1);
        chk("lit_pred_pc", 64'(out_pc_o[31:0]), 64'h2000);
        out_accept_i = 2'b01;
        tick();

        // Fill to full, then check accept gating around the full mark
        for (int n = 0; n < 4; n++) begin
            send(32'h4000 + 32'(8 * n), 2'b00, 0, 0, 2'b00);
            tick();
        end
        chk("lit_full_level", 64'(level_o), 8);
        chk("lit_full_accept", 64'(fetch_accept_o), 0);
        send(32'h4020, 2'b00, 0, 0, 2'b11);
        #1;
        chk("lit_full_pop_accept", 64'(fetch_accept_o), 0);
        tick();
        chk("lit_after_pop_level", 64'(level_o), 6);
        chk("lit_after_pop_accept", 64'(fetch_accept_o), 1);
        chk("lit_after_pop_pc", 64'(out_pc_o[31:0]), 64'h4008);
        send(32'h4020, 2'b00, 0, 0, 2'b00);
        tick();
        out_accept_i = 2'b01;
        tick();
        chk("lit_level7", 64'(level_o), 7);
        chk("lit_level7_accept", 64'(fetch_accept_o), 0);

        // Accept on lane 1 only is ignored
        out_accept_i = 2'b10;
        tick();
        chk("lit_gap_level", 64'(level_o), 7);
        chk("lit_gap_pc", 64'(out_pc_o[31:0]), 64'h400C);
        out_accept_i = 2'b11;
        tick();
        chk("lit_level5", 64'(level_o), 5);

        // Flush with a concurrent push
        send(32'h6000, 2'b00, 0, 0, 2'b11);
        branch_request_i = 1'b1;
        #1;
        chk("lit_flush_valid", 64'(out_valid_o), 0);
        tick();
        chk("lit_flush_level", 64'(level_o), 0);

        // Page fault packet: one entry, no instruction
        send(32'h3004, 2'b10, 0, 1, 2'b00);
        tick();
        chk("lit_fault_level", 64'(level_o), 1);
        chk("lit_fault_instr", 64'(out_instr_o[31:0]), 0);
        chk("lit_fault_page", 64'(out_fault_page_o[0]), 1);
        chk("lit_fault_pc", 64'(out_pc_o[31:0]), 64'h3004);
        chk("lit_fault_pred", 64'(out_pred_branch_o[0]), 0);
        out_accept_i = 2'b01;
        tick();

        // Streaming across the wrap point
        for (int n = 0; n < 20; n++) begin
            send(32'h8000 + 32'(8 * n), 2'b00, 0, 0, 2'b11);
            tick();
        end
        repeat (6) begin
            out_accept_i = 2'b11;
            tick();
        end
        chk("lit_stream_drained", 64'(level_o), 0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            send({$urandom} & 32'hFFFF_FFFC,
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 24) == 0,
                 2'($urandom));
            fetch_valid_i    = $urandom_range(0, 3) != 0;
            branch_request_i = $urandom_range(0, 29) == 0;
            tick();
        end

        // Asynchronous reset in the middle of traffic
        send(32'hA000, 2'b00, 0, 0, 2'b00);
        tick();
        send(32'hA008, 2'b00, 0, 0, 2'b00);
        tick();
        rst_ni = 1'b0;
        #1;
        chk("lit_async_rst_level", 64'(level_o), 0);
        chk("lit_async_rst_valid", 64'(out_valid_o), 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        send(32'h9000, 2'b00, 0, 0, 2'b00);
        tick();
        chk("lit_first_push_level", 64'(level_o), 2);
        chk("lit_first_push_pc", 64'(out_pc_o[31:0]), 64'h9000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/biriscv_fetch_queue.md
# biriscv_fetch_queue

Parametrised instruction queue between the fetch unit and the decoders. It replaces the fixed two-wide fetch-to-decode coupling. Fetch packets of FETCH_W 32-bit instructions are unpacked into per-instruction entries of a DEPTH-deep circular buffer and presented in order on ISSUE_W output lanes. Invalid leading slots and slots after a predicted-taken branch are dropped. The queue flushes on pipeline branch requests.

## Interface
- FETCH_W, 2: instructions per input packet (power of two, 1..4)
- FETCH_W_W, 1: log2(FETCH_W) (0 allowed when FETCH_W=1)
- ISSUE_W, 2: output lanes (1..FETCH_W*2)
- DEPTH, 8: instruction entries (power of two, ≥ FETCH_W+ISSUE_W)
- DEPTH_W, 3: log2(DEPTH)
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous assert, active-low
- fetch_valid_i  input  1  packet valid
- fetch_instr_i  input  32*FETCH_W  packet, slot k at [32k+:32]
- fetch_pc_i  input  32  PC of first valid instruction; bits [2+:FETCH_W_W] give the start slot
- fetch_pred_branch_i  input  FETCH_W  per-slot predicted-taken
- fetch_fault_fetch_i  input  1  bus error on packet
- fetch_fault_page_i  input  1  page fault on packet
- fetch_accept_o  output  1  queue can take a packet this cycle
- branch_request_i  input  1  flush
- out_valid_o  output  ISSUE_W  lane valid, contiguous from lane 0
- out_instr_o  output  32*ISSUE_W  lane instructions
- out_pc_o  output  32*ISSUE_W  lane PCs
- out_pred_branch_o  output  ISSUE_W  lane predicted-taken
- out_fault_fetch_o / out_fault_page_o  output  ISSUE_W each  lane fault flags
- out_accept_i  input  ISSUE_W  lane consumed
- level_o  output  DEPTH_W+1  current occupancy

## Operation
- Slot mask: slot k is pushed iff k ≥ start slot and no slot j in [start, k) has fetch_pred_branch_i[j]=1. The first taken slot is itself pushed.
- Entry PC = {fetch_pc_i[31:2+FETCH_W_W], k[FETCH_W_W-1:0], 2'b00}.
- Fault packet (either fault bit): exactly one entry is pushed, at the start slot. It has instr=0, the fault flags set, and pred=0.
- Push occurs when fetch_valid_i && fetch_accept_o && !branch_request_i. Entries are written at wr_ptr+i in slot order, and wr_ptr advances by the number of pushed slots.
- fetch_accept_o = rst_ni && (DEPTH - count ≥ FETCH_W). The check uses the current count only; a same-cycle pop is not credited.
- Output lane i shows entry rd_ptr+i. out_valid_o[i] = (count > i) && !branch_request_i.
- Pop count is the length of the leading run of ones in (out_accept_i & out_valid_o). Accepts after the first zero are ignored.
- count_next = count + pushed − popped, range 0..DEPTH.
- Pointers are DEPTH_W bits and wrap modulo DEPTH.
- Flush: on branch_request_i, count, rd_ptr and wr_ptr go to 0 at the next edge. Pushes and pops in the flush cycle are discarded, and flush has priority over both.
- Accepting on a lane with out_valid_o=0 is a no-op.

## Timing
- Reset (rst_ni low, async):
  - count=0 and pointers=0.
  - All outputs are 0, including fetch_accept_o (gated by rst_ni) and level_o.
  - Entry storage is not reset.
- Push-to-output latency is 1 cycle; with BIRISCV_FQ_BYPASS_EN and an empty queue it is 0.
- Throughput is up to FETCH_W pushes and ISSUE_W pops per cycle, simultaneously.
- Full: with count > DEPTH−FETCH_W, fetch_accept_o=0 even if a pop is in progress.
- Wrap-around: a multi-slot push or pop spanning index DEPTH−1→0 must be seamless.
- Reset asserted mid-operation clears state immediately; the first push is possible on the first edge after rst_ni rises.

## Configuration
- BIRISCV_FQ_BYPASS_EN defined:
  - When count==0 and a push is accepted, output lanes show the masked packet slots combinationally in the same cycle.
  - Lanes accepted in that cycle are not written.
  - Remaining slots are written as normal.
- Undefined: no combinational path from fetch_* to out_*; outputs are driven from storage only.

## Structure
- biriscv_fq_pkg holds the entry field widths and the entry struct/bit layout {pc[31:2], instr, pred, fault_fetch, fault_page}. Entry PC bits [1:0] are always zero.
- Sub-module biriscv_fq_slot_mask is combinational: start slot + pred bits + fault → pushed mask and push count.
- Top level holds the pointers, count, storage array, lane muxing, pop-count logic and bypass.

## Test plan
- FETCH_W=2, PC 0x1004, no pred → one entry pushed (slot 1, PC 0x1004); level_o=1 next cycle; lane0 PC 0x1004.
- PC 0x2000, pred=2'b01 → only slot 0 pushed, with out_pred_branch_o[0]=1; slot 1 dropped.
- Fill to DEPTH=8 with 4 packets and no accept → fetch_accept_o=0 when level_o=7 or 8; one pop of 2 at level 8 keeps accept at 0 that cycle and gives 1 next cycle.
- out_accept_i=2'b10 with both lanes valid → nothing popped and level_o unchanged.
- Push and pop across index 7→0 for 20 packets → output PCs strictly sequential per packet, no loss or duplication.
- branch_request_i with level 5 and a concurrent push → out_valid_o=0 that cycle, level_o=0 next; fault packet (fault_page=1, PC 0x3004) → single entry, instr 0, out_fault_page_o[0]=1.
